// File: rtl/iir_biquad_param_if.sv
// Sample handshake, clear and status bundle between cascaded iir_biquad_param sections.
interface iir_biquad_param_if #(
    parameter int DATA_W = 16
);
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_val;
    logic                     out_valid;
    logic signed [DATA_W-1:0] y_val;
    logic                     ovf;

    modport master (
        output clear, in_valid, x_val,
        input  in_ready, out_valid, y_val, ovf
    );

    modport slave (
        input  clear, in_valid, x_val,
        output in_ready, out_valid, y_val, ovf
    );
endinterface

// File: rtl/iir_biquad_param.sv
// Direct-form-I biquad: three-cycle IDLE/CALC/SAT sequencer, wide accumulator,
// scaling shift, output clamp with sticky overflow flag.
module iir_biquad_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 0,
    parameter int B0     = 3,
    parameter int B1     = 0,
    parameter int B2     = 0,
    parameter int A1     = 2,
    parameter int A2     = 0
) (
    input  logic               clk,
    input  logic               rst,
    iir_biquad_param_if.slave  bus
);
    localparam int ACC_W = DATA_W + COEF_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SAT  = 2'd2
    } state_e;

    localparam logic signed [COEF_W-1:0] B0_C = COEF_W'(B0);
    localparam logic signed [COEF_W-1:0] B1_C = COEF_W'(B1);
    localparam logic signed [COEF_W-1:0] B2_C = COEF_W'(B2);
    localparam logic signed [COEF_W-1:0] A1_C = COEF_W'(A1);
    localparam logic signed [COEF_W-1:0] A2_C = COEF_W'(A2);

    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sext_d(input logic signed [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_c(input logic signed [COEF_W-1:0] v);
        return {{(ACC_W-COEF_W){v[COEF_W-1]}}, v};
    endfunction

    function automatic logic out_of_range(input logic signed [ACC_W-1:0] v);
        return (v > Y_MAX) || (v < Y_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > Y_MAX) begin
            r = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < Y_MIN) begin
            r = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] x0_q, x0_d;
    logic signed [DATA_W-1:0] x1_q, x1_d;
    logic signed [DATA_W-1:0] x2_q, x2_d;
    logic signed [DATA_W-1:0] y1_q, y1_d;
    logic signed [DATA_W-1:0] y2_q, y2_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] y_val_q, y_val_d;
    logic                     out_valid_q, out_valid_d;
    logic                     ovf_q, ovf_d;

    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [ACC_W-1:0]  res_s;
    logic signed [DATA_W-1:0] y_sat_s;
    logic                     sat_s;

    // Datapath: accumulator sum from current history and scaled/clamped result.
    always_comb begin
        acc_sum_s = sext_c(B0_C) * sext_d(x0_q)
                  + sext_c(B1_C) * sext_d(x1_q)
                  + sext_c(B2_C) * sext_d(x2_q)
                  - sext_c(A1_C) * sext_d(y1_q)
                  - sext_c(A2_C) * sext_d(y2_q);
        res_s     = acc_q >>> SHIFT;
        y_sat_s   = clamp(res_s);
        sat_s     = out_of_range(res_s);
    end

    // Sequencer and history update; clear overrides everything else.
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;
        acc_d       = acc_q;
        y_val_d     = y_val_q;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        if (bus.clear) begin
            state_d = IDLE;
            x0_d    = '0;
            x1_d    = '0;
            x2_d    = '0;
            y1_d    = '0;
            y2_d    = '0;
            acc_d   = '0;
            y_val_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x0_d    = bus.x_val;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    acc_d   = acc_sum_s;
                    state_d = SAT;
                end
                SAT: begin
                    y_val_d     = y_sat_s;
                    out_valid_d = 1'b1;
                    x2_d        = x1_q;
                    x1_d        = x0_q;
                    y2_d        = y1_q;
                    y1_d        = y_sat_s;
                    ovf_d       = ovf_q | sat_s;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            acc_q       <= '0;
            y_val_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
            acc_q       <= acc_d;
            y_val_q     <= y_val_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.y_val     = y_val_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_iir_biquad_param.sv
// Four differently parameterised sections driven in lockstep and compared
// against a plain-arithmetic recurrence model.
module tb_iir_biquad_param;
    localparam int ND = 4;
    localparam int CB0 [ND] = '{3, 1, 16384, -32768};
    localparam int CB1 [ND] = '{0, 2, 0, 12000};
    localparam int CB2 [ND] = '{0, 1, 0, -7};
    localparam int CA1 [ND] = '{2, 0, 0, -40};
    localparam int CA2 [ND] = '{0, 0, 0, 30};
    localparam int CSH [ND] = '{0, 0, 14, 6};

    logic clk;
    logic rst;
    logic clear;
    logic in_valid;
    logic signed [15:0] x_val;
    logic [ND-1:0] ov_s;
    logic [ND-1:0] rdy_s;
    logic [ND-1:0] ovf_s;
    logic [ND-1:0][15:0] yv_s;

    int n_checks = 0;
    int n_fail = 0;

    longint mx1 [ND];
    longint mx2 [ND];
    longint my1 [ND];
    longint my2 [ND];
    bit     movf [ND];
    longint my [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        iir_biquad_param_if #(.DATA_W(16)) bus ();
        assign bus.clear    = clear;
        assign bus.in_valid = in_valid;
        assign bus.x_val    = x_val;
        assign ov_s[g]      = bus.out_valid;
        assign rdy_s[g]     = bus.in_ready;
        assign ovf_s[g]     = bus.ovf;
        assign yv_s[g]      = bus.y_val;
        iir_biquad_param #(
            .DATA_W(16), .COEF_W(16), .SHIFT(CSH[g]),
            .B0(CB0[g]), .B1(CB1[g]), .B2(CB2[g]), .A1(CA1[g]), .A2(CA2[g])
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < ND; k++) begin
            mx1[k] = 0; mx2[k] = 0; my1[k] = 0; my2[k] = 0; movf[k] = 1'b0; my[k] = 0;
        end
    endfunction

    function automatic void model_step(input int k, input longint x);
        longint acc;
        longint res;
        longint y;
        acc = longint'(CB0[k]) * x + longint'(CB1[k]) * mx1[k] + longint'(CB2[k]) * mx2[k]
            - longint'(CA1[k]) * my1[k] - longint'(CA2[k]) * my2[k];
        res = acc >>> CSH[k];
        y = res;
        if (res > 32767) y = 32767;
        if (res < -32768) y = -32768;
        if (y != res) movf[k] = 1'b1;
        mx2[k] = mx1[k]; mx1[k] = x;
        my2[k] = my1[k]; my1[k] = y;
        my[k] = y;
    endfunction

    // Called at a falling edge with all sections idle; leaves in_valid high when keep=1.
    task automatic do_sample(input logic signed [15:0] x, input bit keep);
        int lat;
        in_valid = 1'b1;
        x_val = x;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (ov_s[0]) lat = c;
        end
        check("latency", lat, 3);
        for (int k = 0; k < ND; k++) begin
            model_step(k, longint'(x));
            check($sformatf("out_valid%0d", k), ov_s[k], 1);
            check($sformatf("y%0d", k), $signed(yv_s[k]), my[k]);
            check($sformatf("ovf%0d", k), ovf_s[k], movf[k]);
        end
        check("in_ready_at_result", rdy_s[0], 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
    endtask

    int exp_a [5] = '{27, -12, 45, -60, 147};
    int xs_a  [5] = '{9, 14, 7, 10, 9};
    int exp_b [5] = '{30, -30, 90, -150, 330};
    int exp_d [5] = '{100, 200, 100, 0, 0};
    int pulses;

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        in_valid = 1'b1;
        x_val = 16'sd9;
        model_clear();
        repeat (3) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rst_y%0d", k), $signed(yv_s[k]), 0);
            check($sformatf("rst_ovf%0d", k), ovf_s[k], 0);
            check($sformatf("rst_ovalid%0d", k), ov_s[k], 0);
            check($sformatf("rst_ready%0d", k), rdy_s[k], 1);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (ov_s != '0) pulses++; end
        check("idle_pulses", pulses, 0);

        // Basic sequence with in_valid held high.
        for (int i = 0; i < 5; i++) begin
            do_sample(16'(xs_a[i]), i < 4);
            check($sformatf("seq_a%0d", i), $signed(yv_s[0]), exp_a[i]);
        end
        check("seq_a_ovf", ovf_s[0], 0);

        // Divergent stream of 10 saturates in both directions.
        do_clear();
        for (int i = 0; i < 14; i++) begin
            do_sample(16'sd10, i < 13);
            if (i < 5) check($sformatf("seq_b%0d", i), $signed(yv_s[0]), exp_b[i]);
            if (i == 10) check("ovf_before_clamp", ovf_s[0], 0);
            if (i == 11) begin
                check("clamp_neg", $signed(yv_s[0]), -32768);
                check("ovf_first_clamp", ovf_s[0], 1);
            end
            if (i == 12) check("clamp_pos", $signed(yv_s[0]), 32767);
        end
        check("ovf_sticky", ovf_s[0], 1);

        // Clear while the sample is in CALC.
        @(negedge clk);
        in_valid = 1'b1;
        x_val = 16'sd9;
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_y", $signed(yv_s[0]), 0);
        check("clr_ovf", ovf_s[0], 0);
        check("clr_ready", rdy_s[0], 1);
        pulses = 0;
        repeat (5) begin @(negedge clk); if (ov_s != '0) pulses++; end
        check("clr_pulses", pulses, 0);
        model_clear();
        do_sample(16'sd9, 1'b0);
        check("after_clr", $signed(yv_s[0]), 27);

        // Impulse through the FIR-only section.
        do_clear();
        for (int i = 0; i < 5; i++) begin
            do_sample(i == 0 ? 16'sd100 : 16'sd0, i < 4);
            check($sformatf("impulse%0d", i), $signed(yv_s[1]), exp_d[i]);
        end

        // Fractional scaling keeps the sign.
        do_clear();
        do_sample(-16'sd3, 1'b1);
        check("shift_neg", $signed(yv_s[2]), -3);
        do_sample(16'sd5, 1'b0);
        check("shift_pos", $signed(yv_s[2]), 5);

        // Random samples, random back-to-back or gapped.
        do_clear();
        for (int i = 0; i < 40; i++) begin
            bit keep;
            keep = 1'($urandom_range(0, 1));
            do_sample(16'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Asynchronous reset while the second sample sits in SAT.
        do_sample(16'sd9, 1'b1);
        x_val = 16'sd14;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("arst_y%0d", k), $signed(yv_s[k]), 0);
            check($sformatf("arst_ovf%0d", k), ovf_s[k], 0);
            check($sformatf("arst_ready%0d", k), rdy_s[k], 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_sample(16'sd9, 1'b0);
        check("after_arst", $signed(yv_s[0]), 27);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/iir_biquad_param.md
Name: iir_biquad_param

Overview:
- Parametrised second-order IIR section (direct form I), the successor of the fixed first-order filter (y = -2*y[n-1] + 3*x[n]).
- Coefficients, data width and fractional scaling are parameters.
- Adds a valid/ready sample handshake, a synchronous clear, output saturation and a sticky overflow flag.
- Sits in the filter chain; sections cascade by connecting out_valid/y_val to in_valid/x_val of the next section.

Parameters:
- DATA_W, 16: signed sample width of x_val and y_val.
- COEF_W, 16: signed coefficient width.
- SHIFT, 0: arithmetic right shift applied to the accumulator (coefficient fractional bits).
- B0, 3: feed-forward coefficient for x[n].
- B1, 0: feed-forward coefficient for x[n-1].
- B2, 0: feed-forward coefficient for x[n-2].
- A1, 2: feedback coefficient for y[n-1], subtracted.
- A2, 0: feedback coefficient for y[n-2], subtracted.

Ports:
- clk  in  1: clock; all state changes on its rising edge.
- rst  in  1: reset, asynchronous, active-high.
- clear  in  1: synchronous clear of history, flag and in-flight sample.
- in_valid  in  1: x_val holds a sample.
- in_ready  out  1: block can accept a sample (high only in IDLE).
- x_val  in  DATA_W: signed input sample.
- out_valid  out  1: one-cycle pulse; y_val holds a new result.
- y_val  out  DATA_W: signed filtered output, registered, held between results.
- ovf  out  1: sticky flag, set when any result saturated.

Behaviour:
- Recurrence: acc = B0*x[n] + B1*x[n-1] + B2*x[n-2] - A1*y[n-1] - A2*y[n-2].
  - acc width is DATA_W+COEF_W+3 bits, signed; no intermediate overflow.
  - res = acc >>> SHIFT (arithmetic, truncates toward -inf).
  - y[n] = res clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - History stores the clamped y[n], not the raw result.
- Reset (rst=1, asynchronous):
  - state = IDLE.
  - x1, x2, y1, y2, y_val, ovf = 0; out_valid = 0.
  - in_ready = 1 (state is IDLE), but no transfer takes effect while rst is high.
- FSM states IDLE, CALC, SAT.
  - IDLE: in_ready = 1. A transfer occurs when in_valid=1 on a rising edge; x_val is latched into x0 and the FSM moves to CALC. With in_valid=0 it stays in IDLE.
  - CALC: in_ready = 0. At the next edge acc is registered and the FSM moves to SAT.
  - SAT: in_ready = 0. At the next edge:
    - y_val <= y[n]; out_valid <= 1 for exactly one cycle.
    - x2 <= x1, x1 <= x0, y2 <= y1, y1 <= y[n].
    - ovf <= ovf | (res was out of range).
    - FSM returns to IDLE.
- Latency: transfer at edge E0 -> y_val valid and out_valid high in the cycle after edge E2 (3 edges). Throughput is one sample per 3 cycles.
- A new transfer may occur in the same cycle out_valid is high (the FSM is in IDLE).
- in_valid outside IDLE is ignored. The upstream must hold the sample until in_ready is seen.
- clear=1 at an edge, in any state:
  - Takes priority over in_valid and FSM progress.
  - Zeroes x1, x2, y1, y2, y_val and ovf; state goes to IDLE; out_valid = 0.
  - Any in-flight sample is discarded and produces no out_valid.
- rst asserted mid-computation aborts immediately to the reset values.
- Saturation applies in both directions. ovf stays 1 until rst or clear.
- Coefficient value -2^(COEF_W-1) is legal; the accumulator width covers it.

Test Plan:
- Defaults, rst pulse, then x = 9,14,7,10,9 with in_valid held high -> y_val = 27, -12, 45, -60, 147, one out_valid per sample, 3-cycle spacing; ovf = 0.
- Defaults, continuous stream of x = 10 -> y = 30, -30, 90, -150, 330 ... The result clamps to 32767 or -32768 once |y| exceeds range; ovf rises on the first clamped sample and stays 1; the next y is computed from the clamped history.
- B0=1, B1=2, B2=1, A1=A2=0, single impulse x=100 then zeros -> y = 100, 200, 100, 0, 0.
- B0=16384, A1=0, SHIFT=14, x = -3 -> y = -3; x = 5 -> y = 5 (arithmetic shift, sign preserved).
- clear asserted during CALC after a transfer -> no out_valid for that sample; y_val=0, ovf=0, history zero; the next x=9 (defaults) gives 27.
- rst asserted asynchronously mid-SAT -> outputs are 0 immediately, before the next edge; after release, x=9 gives 27. in_valid held high in CALC/SAT does not cause an extra transfer.
